// File: rtl/half_pel_column_builder_pkg.sv
// Shared constants, HEVC luma quarter/half/three-quarter tap tables, state encoding
// and the round/clip step used by the horizontal first-stage filter.
package half_pel_column_builder_pkg;

  localparam int PIX_W        = 8;
  localparam int NUM_PIXEL    = 8;
  localparam int NUM_ROWS     = 15;
  localparam int NUM_TAPS     = 8;
  localparam int ROUND_OFFSET = 32;
  localparam int SHIFT        = 6;
  localparam int SUM_W        = 17;
  localparam int MAX_PIX      = 255;

  typedef logic signed [7:0] coef_t;

  localparam coef_t COEF_A [NUM_TAPS] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58,
                                          8'sd17, -8'sd5, 8'sd1, 8'sd0};
  localparam coef_t COEF_B [NUM_TAPS] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40,
                                          8'sd40, -8'sd11, 8'sd4, -8'sd1};
  localparam coef_t COEF_C [NUM_TAPS] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17,
                                          8'sd58, -8'sd10, 8'sd4, -8'sd1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Round to nearest with a floor shift, then saturate into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] round_clip(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W-1:0] shifted;
    shifted = (sum + SUM_W'(ROUND_OFFSET)) >>> SHIFT;
    if (shifted[SUM_W-1])
      round_clip = '0;
    else if (shifted > SUM_W'(MAX_PIX))
      round_clip = '1;
    else
      round_clip = shifted[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/hevc_8tap_filter.sv
// One output position: 8 unsigned samples through the A/B/C 8-tap kernels.
// Sums are registered (1 cycle); round/clip is combinational off the sum registers.
module hevc_8tap_filter
  import half_pel_column_builder_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_TAPS*PIX_W-1:0] samples,
  output logic [PIX_W-1:0]          a_pix,
  output logic [PIX_W-1:0]          b_pix,
  output logic [PIX_W-1:0]          c_pix
);

  logic signed [SUM_W-1:0] sum_a;
  logic signed [SUM_W-1:0] sum_b;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] pix;
  logic signed [SUM_W-1:0] sum_a_q;
  logic signed [SUM_W-1:0] sum_b_q;
  logic signed [SUM_W-1:0] sum_c_q;

  always_comb begin
    sum_a = '0;
    sum_b = '0;
    sum_c = '0;
    pix   = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      pix   = SUM_W'($signed({1'b0, samples[t*PIX_W +: PIX_W]}));
      sum_a = sum_a + pix * SUM_W'(COEF_A[t]);
      sum_b = sum_b + pix * SUM_W'(COEF_B[t]);
      sum_c = sum_c + pix * SUM_W'(COEF_C[t]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_a_q <= '0;
      sum_b_q <= '0;
      sum_c_q <= '0;
    end else begin
      sum_a_q <= sum_a;
      sum_b_q <= sum_b;
      sum_c_q <= sum_c;
    end
  end

  assign a_pix = round_clip(sum_a_q);
  assign b_pix = round_clip(sum_b_q);
  assign c_pix = round_clip(sum_c_q);

endmodule

// File: rtl/half_pel_column_builder.sv
// Horizontal sub-pel pass: 15 integer rows in, three transposed 8x15 phase arrays out.
// Row accepted -> written 2 edges later; rows only taken while row_ready (COLLECT), stalls just wait.
module half_pel_column_builder #(
  parameter int NUM_PIXEL = half_pel_column_builder_pkg::NUM_PIXEL,
  parameter int NUM_ROWS  = half_pel_column_builder_pkg::NUM_ROWS,
  parameter int PIX_W     = half_pel_column_builder_pkg::PIX_W
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                row_valid,
  input  logic [NUM_ROWS*PIX_W-1:0]           row_in,
  output logic                                row_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                arrays_valid,
  output logic [NUM_PIXEL*NUM_ROWS*PIX_W-1:0] a_half_array,
  output logic [NUM_PIXEL*NUM_ROWS*PIX_W-1:0] b_half_array,
  output logic [NUM_PIXEL*NUM_ROWS*PIX_W-1:0] c_half_array
);

  import half_pel_column_builder_pkg::*;

  localparam int CNT_W = $clog2(NUM_ROWS);

  state_t                    state;
  logic [CNT_W-1:0]          row_cnt;
  logic                      drain_cnt;
  logic                      accept;

  // Stage 0: captured row and its slot index; stage 1 tracks the index alongside the sum registers.
  logic                      s0_vld;
  logic [CNT_W-1:0]          s0_idx;
  logic [NUM_ROWS*PIX_W-1:0] s0_row;
  logic                      s1_vld;
  logic [CNT_W-1:0]          s1_idx;

  logic [PIX_W-1:0]          a_pix [NUM_PIXEL];
  logic [PIX_W-1:0]          b_pix [NUM_PIXEL];
  logic [PIX_W-1:0]          c_pix [NUM_PIXEL];

  assign accept = row_valid && row_ready;

  for (genvar j = 0; j < NUM_PIXEL; j++) begin : g_pos
    hevc_8tap_filter u_filter (
      .clock   (clock),
      .reset   (reset),
      .samples (s0_row[j*PIX_W +: NUM_TAPS*PIX_W]),
      .a_pix   (a_pix[j]),
      .b_pix   (b_pix[j]),
      .c_pix   (c_pix[j])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s0_vld <= 1'b0;
      s0_idx <= '0;
      s0_row <= '0;
      s1_vld <= 1'b0;
      s1_idx <= '0;
    end else begin
      s0_vld <= accept;
      if (accept) begin
        s0_idx <= row_cnt;
        s0_row <= row_in;
      end
      s1_vld <= s0_vld;
      s1_idx <= s0_idx;
    end
  end

  // Transposed write: row r of position j lands in slot r of column j.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_half_array <= '0;
      b_half_array <= '0;
      c_half_array <= '0;
    end else if (s1_vld) begin
      for (int j = 0; j < NUM_PIXEL; j++) begin
        a_half_array[(j*NUM_ROWS + int'(s1_idx))*PIX_W +: PIX_W] <= a_pix[j];
        b_half_array[(j*NUM_ROWS + int'(s1_idx))*PIX_W +: PIX_W] <= b_pix[j];
        c_half_array[(j*NUM_ROWS + int'(s1_idx))*PIX_W +: PIX_W] <= c_pix[j];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      drain_cnt    <= 1'b0;
      row_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      arrays_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_COLLECT;
            row_cnt      <= '0;
            row_ready    <= 1'b1;
            busy         <= 1'b1;
            arrays_valid <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == CNT_W'(NUM_ROWS-1)) begin
              state     <= ST_DRAIN;
              row_ready <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            arrays_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_pel_column_builder.sv
// Directed bench for the column builder: hand-computed spot values plus a tap-table model for full arrays.
module tb_half_pel_column_builder;

  localparam int NP  = 8;
  localparam int NR  = 15;
  localparam int PW  = 8;
  localparam int RW  = NR*PW;
  localparam int AW  = NP*NR*PW;

  localparam int CA [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int CB [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int CC [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

  logic          clock;
  logic          reset;
  logic          start;
  logic          row_valid;
  logic [RW-1:0] row_in;
  logic          row_ready;
  logic          busy;
  logic          done;
  logic          arrays_valid;
  logic [AW-1:0] a_half_array;
  logic [AW-1:0] b_half_array;
  logic [AW-1:0] c_half_array;

  logic [AW-1:0] exp_a;
  logic [AW-1:0] exp_b;
  logic [AW-1:0] exp_c;

  int checks;
  int failures;

  half_pel_column_builder dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .row_valid    (row_valid),
    .row_in       (row_in),
    .row_ready    (row_ready),
    .busy         (busy),
    .done         (done),
    .arrays_valid (arrays_valid),
    .a_half_array (a_half_array),
    .b_half_array (b_half_array),
    .c_half_array (c_half_array)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [119:0] got, input logic [119:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int ph, input logic [RW-1:0] row, input int j);
    int s;
    int c;
    s = 0;
    for (int t = 0; t < 8; t++) begin
      c = (ph == 0) ? CA[t] : (ph == 1) ? CB[t] : CC[t];
      s += c * int'(row[(j+t)*8 +: 8]);
    end
    s = (s + 32) >>> 6;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s[7:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic model_row(input logic [RW-1:0] row, input int idx);
    for (int j = 0; j < NP; j++) begin
      exp_a[(j*NR + idx)*8 +: 8] = ref_pix(0, row, j);
      exp_b[(j*NR + idx)*8 +: 8] = ref_pix(1, row, j);
      exp_c[(j*NR + idx)*8 +: 8] = ref_pix(2, row, j);
    end
  endtask

  task automatic send_row(input logic [RW-1:0] row, input int idx);
    row_valid = 1'b1;
    row_in    = row;
    step();
    row_valid = 1'b0;
    model_row(row, idx);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk(tag, 120'(done), 120'(1'b1));
  endtask

  task automatic cmp_arrays(input string tag);
    for (int j = 0; j < NP; j++) begin
      chk($sformatf("%s A%0d", tag, j), a_half_array[j*RW +: RW], exp_a[j*RW +: RW]);
      chk($sformatf("%s B%0d", tag, j), b_half_array[j*RW +: RW], exp_b[j*RW +: RW]);
      chk($sformatf("%s C%0d", tag, j), c_half_array[j*RW +: RW], exp_c[j*RW +: RW]);
    end
  endtask

  logic [RW-1:0]  row;
  logic [127:0]   rnd;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    row_valid = 1'b0;
    row_in    = '0;
    exp_a     = '0;
    exp_b     = '0;
    exp_c     = '0;
    step();
    step();
    reset = 1'b0;
    step();

    chk("rst_ready", 120'(row_ready), 120'(1'b0));
    chk("rst_busy", 120'(busy), 120'(1'b0));
    chk("rst_done", 120'(done), 120'(1'b0));
    chk("rst_avalid", 120'(arrays_valid), 120'(1'b0));
    cmp_arrays("rst");

    // row_valid while IDLE must not write anything
    row_valid = 1'b1;
    row_in    = '1;
    step();
    step();
    row_valid = 1'b0;
    step();
    step();
    chk("idle_busy", 120'(busy), 120'(1'b0));
    cmp_arrays("idle");

    // Flat block, back-to-back, with exact done timing
    do_start();
    chk("flat_ready", 120'(row_ready), 120'(1'b1));
    chk("flat_busy", 120'(busy), 120'(1'b1));
    for (int r = 0; r < NR; r++) send_row({NR{8'd100}}, r);
    chk("flat_done_n0", 120'(done), 120'(1'b0));
    chk("flat_ready_drain", 120'(row_ready), 120'(1'b0));
    step();
    chk("flat_done_n1", 120'(done), 120'(1'b0));
    step();
    chk("flat_done_n2", 120'(done), 120'(1'b1));
    chk("flat_avalid", 120'(arrays_valid), 120'(1'b1));
    chk("flat_busy_done", 120'(busy), 120'(1'b0));
    chk("flat_a_byte", 120'(a_half_array[7:0]), 120'(8'd100));
    chk("flat_c_last", 120'(c_half_array[AW-1 -: 8]), 120'(8'd100));
    cmp_arrays("flat");

    // Start in the done cycle: the pulse already seen, new block begins
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2_avalid_drop", 120'(arrays_valid), 120'(1'b0));
    chk("b2_done_low", 120'(done), 120'(1'b0));
    chk("b2_ready", 120'(row_ready), 120'(1'b1));
    row = '0;
    row[15:8]  = 8'd255;
    row[31:24] = 8'd255;
    row[39:32] = 8'd255;
    row[55:48] = 8'd255;
    send_row(row, 0);
    for (int r = 1; r < NR; r++) send_row('0, r);
    wait_done("clip_done");
    chk("clip_b00", 120'(b_half_array[7:0]), 120'(8'd255));
    cmp_arrays("clip");

    // Impulse block with 1/0 valid toggling and a start pulse mid-COLLECT
    step();
    do_start();
    chk("imp_avalid_drop", 120'(arrays_valid), 120'(1'b0));
    for (int r = 0; r < NR; r++) begin
      row = '0;
      if (r == 3) row[31:24] = 8'd255;
      send_row(row, r);
      if (r == 5) start = 1'b1;
      step();
      start = 1'b0;
    end
    wait_done("imp_done");
    chk("imp_a_c0s3", 120'(a_half_array[3*8 +: 8]), 120'(8'd231));
    chk("imp_b_c0s3", 120'(b_half_array[3*8 +: 8]), 120'(8'd159));
    chk("imp_c_c0s3", 120'(c_half_array[3*8 +: 8]), 120'(8'd68));
    chk("imp_a_c1s3", 120'(a_half_array[(NR+3)*8 +: 8]), 120'(8'd0));
    chk("imp_a_c2s3", 120'(a_half_array[(2*NR+3)*8 +: 8]), 120'(8'd16));
    chk("imp_b_c2s3", 120'(b_half_array[(2*NR+3)*8 +: 8]), 120'(8'd16));
    chk("imp_c_c2s3", 120'(c_half_array[(2*NR+3)*8 +: 8]), 120'(8'd4));
    cmp_arrays("imp");

    // Reset after row 7 of a new block
    do_start();
    for (int r = 0; r < 8; r++) send_row({NR{8'(r*17 + 3)}}, r);
    reset = 1'b1;
    step();
    exp_a = '0;
    exp_b = '0;
    exp_c = '0;
    chk("mrst_ready", 120'(row_ready), 120'(1'b0));
    chk("mrst_busy", 120'(busy), 120'(1'b0));
    chk("mrst_avalid", 120'(arrays_valid), 120'(1'b0));
    cmp_arrays("mrst");
    reset = 1'b0;
    step();
    step();
    step();
    chk("post_rst_ready", 120'(row_ready), 120'(1'b0));
    cmp_arrays("post_rst");

    // Fresh pseudo-random block after the abort
    do_start();
    for (int r = 0; r < NR; r++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      send_row(rnd[RW-1:0], r);
    end
    wait_done("rnd_done");
    chk("rnd_avalid", 120'(arrays_valid), 120'(1'b1));
    cmp_arrays("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
